// File: rtl/fb_writer_if.sv
// Pixel-stream and frame-buffer RAM write bundle for fb_writer.
// The producer (master) drives start/pixels; fb_writer (slave) drives RAM writes and status.
interface fb_writer_if;
    logic        start;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        wren;
    logic [16:0] wraddress;
    logic [31:0] data;
    logic        busy;
    logic        done;

    modport master (
        output start, pix_data, pix_valid,
        input  pix_ready, wren, wraddress, data, busy, done
    );

    modport slave (
        input  start, pix_data, pix_valid,
        output pix_ready, wren, wraddress, data, busy, done
    );
endinterface

// File: rtl/fb_writer.sv
// Packs a byte stream little-endian into 32-bit words and writes one frame
// of FRAME_WORDS words to consecutive RAM addresses starting at BASE_ADDR.
module fb_writer #(
    parameter int FRAME_WORDS = 19200,
    parameter int BASE_ADDR   = 0
) (
    input  logic         clk,
    input  logic         reset,
    fb_writer_if.slave   bus
);

    localparam int              IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [16:0]     BASE_A   = 17'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_word_idx;
    logic [IDX_W-1:0]  w_next_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        w_next_byte_cnt;
    logic [31:0]       r_word;
    logic [31:0]       w_next_word;
    logic [16:0]       r_wraddress;
    logic [16:0]       w_next_wraddress;
    logic [31:0]       r_data;
    logic [31:0]       w_next_data;
    logic              r_pix_ready;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;

    // pix_ready is a register that mirrors COLLECT, so acceptance needs no state decode
    assign w_accept = r_pix_ready & bus.pix_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, word assembly and next output values
    always_comb begin
        w_next_state     = r_state;
        w_next_word_idx  = r_word_idx;
        w_next_byte_cnt  = r_byte_cnt;
        w_next_word      = r_word;
        w_next_wraddress = r_wraddress;
        w_next_data      = r_data;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state    = COLLECT;
                    w_next_word_idx = '0;
                    w_next_byte_cnt = 2'd0;
                end else begin
                    w_next_state    = IDLE;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    w_next_word[{r_byte_cnt, 3'b000} +: 8] = bus.pix_data;
                    if (r_byte_cnt == 2'd3) begin
                        // Address and data are latched here so they hold after WRITE
                        w_next_state     = WRITE;
                        w_next_byte_cnt  = 2'd0;
                        w_next_wraddress = BASE_A + 17'(r_word_idx);
                        w_next_data      = {bus.pix_data, r_word[23:0]};
                    end else begin
                        w_next_byte_cnt  = r_byte_cnt + 2'd1;
                    end
                end else begin
                    w_next_state = COLLECT;
                end
            end
            WRITE: begin
                if (r_word_idx == LAST_IDX) begin
                    w_next_state    = DONE;
                end else begin
                    w_next_state    = COLLECT;
                    w_next_word_idx = r_word_idx + IDX_W'(1);
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word_idx  <= '0;
            r_byte_cnt  <= 2'd0;
            r_word      <= 32'd0;
            r_wraddress <= 17'd0;
            r_data      <= 32'd0;
            r_pix_ready <= 1'b0;
            r_wren      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_word_idx  <= w_next_word_idx;
            r_byte_cnt  <= w_next_byte_cnt;
            r_word      <= w_next_word;
            r_wraddress <= w_next_wraddress;
            r_data      <= w_next_data;
            r_pix_ready <= (w_next_state == COLLECT);
            r_wren      <= (w_next_state == WRITE);
            r_busy      <= (w_next_state == COLLECT) || (w_next_state == WRITE);
            r_done      <= (w_next_state == DONE);
        end
    end

    assign bus.pix_ready = r_pix_ready;
    assign bus.wren      = r_wren;
    assign bus.wraddress = r_wraddress;
    assign bus.data      = r_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FRAME_WORDS, default 19200: number of 32-bit words in one frame (320x240 8-bit pixels).
REQ-002 Parameter BASE_ADDR, default 0: first RAM word address written for each frame.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset (reset=0 sampled on a rising clk edge resets the block).
REQ-005 Port start, input, 1: one-cycle request to begin loading one frame.
REQ-006 Port pix_data, input, 8: pixel byte from the producer.
REQ-007 Port pix_valid, input, 1: pix_data is valid this cycle.
REQ-008 Port pix_ready, output, 1: block accepts a byte this cycle.
REQ-009 Port wren, output, 1: frame-buffer RAM write enable.
REQ-010 Port wraddress, output, 17: frame-buffer RAM word address.
REQ-011 Port data, output, 32: frame-buffer RAM write word.
REQ-012 Port busy, output, 1: frame load in progress.
REQ-013 Port done, output, 1: one-cycle pulse after the last word of a frame is written.

Function
REQ-014 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-015 States: IDLE, COLLECT, WRITE, DONE.
REQ-016 IDLE: pix_ready=0, wren=0, busy=0; start=1 -> COLLECT, word index=0, byte count=0.
REQ-017 COLLECT: pix_ready=1, busy=1; a byte is accepted only on a cycle with pix_valid=1 and pix_ready=1.
REQ-018 Byte packing shall be little-endian: accepted byte k (0..3) goes to word bits [8k+7:8k].
REQ-019 On acceptance of byte 3: byte count -> 0, state -> WRITE.
REQ-020 WRITE (exactly one cycle): wren=1, pix_ready=0, wraddress=BASE_ADDR+word index (17-bit, truncated), data=packed word.
REQ-021 Latency: wren shall assert on the cycle immediately after the cycle in which byte 3 is accepted.
REQ-022 Throughput: at most 4 bytes per 5 cycles; pix_valid may stay high, and unaccepted bytes are held by the producer.
REQ-023 From WRITE: if word index = FRAME_WORDS-1 -> DONE; else word index+1 -> COLLECT.
REQ-024 DONE (one cycle): done=1, busy=0, pix_ready=0, wren=0; then -> IDLE.
REQ-025 start shall be ignored in COLLECT, WRITE and DONE; no restart and no index change.
REQ-026 pix_valid in IDLE or DONE shall be ignored; no byte is accepted.
REQ-027 wren shall never assert outside WRITE; exactly FRAME_WORDS writes per frame, in ascending address order with no gaps.
REQ-028 wraddress and data shall hold their last written values when wren=0.
REQ-029 The word index shall never exceed FRAME_WORDS-1; there is no wrap-around within a frame.

Reset
REQ-030 On reset=0: state=IDLE, pix_ready=0, wren=0, wraddress=0, data=0, busy=0, done=0, word index=0, byte count=0.
REQ-031 Reset mid-frame shall discard the partial word; no write occurs on the reset cycle or after it until a new start.
REQ-032 Reset shall take priority over start and pix_valid in the same cycle.

Verification
REQ-033 Basic word (FRAME_WORDS=2): start, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> next cycle wren=1, wraddress=0, data=0x44332211.
REQ-034 Full frame (FRAME_WORDS=2, BASE_ADDR=100): 8 bytes with continuous pix_valid -> writes at addresses 100 and 101 only, then done=1 for one cycle, then busy=0 and pix_ready=0.
REQ-035 Backpressure/gaps: pix_valid toggles 1,0,0,1,1,0,1 -> exactly 4 bytes accepted, one write; pix_ready=0 during WRITE, with the held byte accepted on the next COLLECT cycle.
REQ-036 Ignored start: start pulses during COLLECT and during DONE -> word index is unchanged and no extra frame begins; IDLE is reached after DONE.
REQ-037 Reset mid-word: 2 bytes accepted, then reset=0 for one cycle -> all outputs at reset values, and no wren; after a new start the first write goes to BASE_ADDR.
REQ-038 Default parameters: 76800 bytes streamed -> 19200 writes at addresses 0..19199 and one done pulse.
